gate_sweep_ctrl: RTL and testbench

Self-test sequencer for the two-input logic-gate unit (NOT/AND/OR outputs). On a start request it drives the four input vectors 00, 01, 10, 11 into the gate unit, waits a programmable settle time per vector, samples the three outputs, and compares them against the expected truth table. It reports pass/fail, a per-vector error mask and a log of captured outputs. It sits beside the gate unit and owns its a/b inputs during a sweep.

---
 rtl/gate_sweep_pkg.sv | 19 +
 rtl/gate_sweep_ctrl_ref.sv | 14 +
 rtl/gate_sweep_ctrl.sv | 143 ++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types and the gate truth-table reference for the gate-unit self-test sequencer.
package gate_sweep_pkg;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned OUT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Expected gate-unit response packed as {not, and, or}.
  function automatic logic [OUT_W-1:0] exp_outputs(input logic a, input logic b);
    return {~a, a & b, a | b};
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_ref.sv
// Combinational expected-value model of the two-input gate unit.
module gate_ref_model
  import gate_sweep_pkg::*;
(
  input  logic             a_i,
  input  logic             b_i,
  output logic [OUT_W-1:0] exp_o
);

  always_comb begin
    exp_o = exp_outputs(a_i, b_i);
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: sweeps a/b through 00..11, settles, samples NOT/AND/OR and
// logs per-vector results against the reference truth table.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        gate_a,
  output logic        gate_b,
  input  logic        gate_not,
  input  logic        gate_and,
  input  logic        gate_or,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_mask,
  output logic [11:0] out_log
);

  localparam int unsigned         CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]          IDX_LAST = 2'(NUM_VECTORS - 1);

  state_e                          state_q, state_d;
  logic [1:0]                      idx_q, idx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            gate_a_q, gate_a_d;
  logic                            gate_b_q, gate_b_d;
  logic                            pass_q, pass_d;
  logic [NUM_VECTORS-1:0]          err_q, err_d;
  logic [NUM_VECTORS*OUT_W-1:0]    log_q, log_d;

  logic [OUT_W-1:0]                exp_vec;
  logic [OUT_W-1:0]                sample;
  logic [1:0]                      idx_nxt;

  gate_ref_model u_ref (
    .a_i   (gate_a_q),
    .b_i   (gate_b_q),
    .exp_o (exp_vec)
  );

  assign sample  = {gate_not, gate_and, gate_or};
  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    gate_a_d = gate_a_q;
    gate_b_d = gate_b_q;
    pass_d   = pass_q;
    err_d    = err_q;
    log_d    = log_q;

    case (state_q)
      ST_IDLE: begin
        gate_a_d = 1'b0;
        gate_b_d = 1'b0;
        if (start && !abort) begin
          state_d = ST_SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          log_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        log_d[idx_q*OUT_W +: OUT_W] = sample;
        if (sample != exp_vec) err_d[idx_q] = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          // Verdict includes the vector captured on this same edge.
          pass_d  = ~|err_d;
        end else begin
          state_d  = ST_SETTLE;
          idx_d    = idx_nxt;
          cnt_d    = '0;
          gate_a_d = idx_nxt[1];
          gate_b_d = idx_nxt[0];
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        gate_a_d = 1'b0;
        gate_b_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any capture in flight; partial results are retained.
    if (abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      cnt_d    = '0;
      gate_a_d = 1'b0;
      gate_b_d = 1'b0;
      pass_d   = 1'b0;
      err_d    = err_q;
      log_d    = log_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      log_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      log_q    <= log_d;
    end
  end

  assign gate_a   = gate_a_q;
  assign gate_b   = gate_b_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign pass     = pass_q;
  assign err_mask = err_q;
  assign out_log  = log_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: behavioural gate unit with fault injection, vector table
// plus scoreboard of expected sweep results, and hand-written abort/reset/start sequences.
module tb_gate_sweep_ctrl;

  typedef struct {
    logic [1:0]  fault;     // {and_stuck0, or_stuck1}
    logic        exp_pass;
    logic [3:0]  exp_mask;
    logic [11:0] exp_log;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic        gate_a, gate_b, gate_not, gate_and, gate_or;
  logic        busy, done, pass;
  logic [3:0]  err_mask;
  logic [11:0] out_log;
  logic        f_and0, f_or1;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[4];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  assign gate_not = ~gate_a;
  assign gate_and = f_and0 ? 1'b0 : (gate_a & gate_b);
  assign gate_or  = f_or1  ? 1'b1 : (gate_a | gate_b);

  gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .gate_a   (gate_a),
    .gate_b   (gate_b),
    .gate_not (gate_not),
    .gate_and (gate_and),
    .gate_or  (gate_or),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_mask (err_mask),
    .out_log  (out_log)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected sweep result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        check("sb_pass", 32'(pass), 32'(e.exp_pass));
        check("sb_err_mask", 32'(err_mask), 32'(e.exp_mask));
        check("sb_out_log", 32'(out_log), 32'(e.exp_log));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_gates"}, 32'({gate_a, gate_b}), 32'd0);
  endtask

  task automatic run_sweep(input vec_t v);
    int  cyc;
    bit  got;
    bit  gate_bad;
    f_and0 = v.fault[1];
    f_or1  = v.fault[0];
    sb_q.push_back(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; got = 0; gate_bad = 0;
    while (cyc <= 40 && !got) begin
      if (done) got = 1;
      else begin
        if (cyc <= 12 && {gate_a, gate_b} !== 2'((cyc - 1) / 3)) gate_bad = 1;
        tick();
        cyc++;
      end
    end
    check("done_cycle", 32'(cyc), 32'd13);
    check("gate_seq", 32'(gate_bad), 32'd0);
    check("busy_at_done", 32'(busy), 32'd1);
    tick();
    check_idle_outputs("after_done");
    check("pass_held", 32'(pass), 32'(v.exp_pass));
    check("mask_held", 32'(err_mask), 32'(v.exp_mask));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_done, d1, d2, cyc;
    bit  seen;

    vecs[0] = '{fault: 2'b00, exp_pass: 1'b1, exp_mask: 4'b0000, exp_log: 12'h66C};
    vecs[1] = '{fault: 2'b10, exp_pass: 1'b0, exp_mask: 4'b1000, exp_log: 12'h26C};
    vecs[2] = '{fault: 2'b01, exp_pass: 1'b0, exp_mask: 4'b0001, exp_log: 12'h66D};
    vecs[3] = '{fault: 2'b11, exp_pass: 1'b0, exp_mask: 4'b1001, exp_log: 12'h26D};

    rst = 1'b1; start = 1'b0; abort = 1'b0; f_and0 = 1'b0; f_or1 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check_idle_outputs("reset");
    check("reset_pass", 32'(pass), 32'd0);
    check("reset_mask", 32'(err_mask), 32'd0);
    check("reset_log", 32'(out_log), 32'd0);

    for (int i = 0; i < 4; i++) run_sweep(vecs[i]);

    // Abort during vector 2 SETTLE with OR stuck high.
    f_and0 = 1'b0; f_or1 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("abort_pre_busy", 32'(busy), 32'd1);
    check("abort_pre_gates", 32'({gate_a, gate_b}), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("abort");
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_mask", 32'(err_mask), 32'h1);
    check("abort_log", 32'(out_log), 32'h02D);
    seen = 0;
    repeat (15) begin
      tick();
      if (done || busy) seen = 1;
    end
    check("abort_quiet", 32'(seen), 32'd0);

    // Start held high (with a re-pulse mid-sweep): back-to-back sweeps, one done each.
    f_and0 = 1'b0; f_or1 = 1'b0;
    sb_q.push_back(vecs[0]);
    sb_q.push_back(vecs[0]);
    start = 1'b1;
    tick();
    n_done = 0; d1 = 0; d2 = 0; cyc = 1;
    while (cyc <= 40 && n_done < 2) begin
      if (cyc == 5) start = 1'b0;
      if (cyc == 8) start = 1'b1;
      if (done) begin
        n_done++;
        if (n_done == 1) d1 = cyc;
        else begin
          d2 = cyc;
          start = 1'b0;
        end
      end
      if (n_done < 2) begin
        tick();
        cyc++;
      end
    end
    check("held_done1", 32'(d1), 32'd13);
    check("held_done2", 32'(d2), 32'd27);
    tick();
    check("held_busy_fall", 32'(busy), 32'd0);
    repeat (3) tick();
    check("held_stays_idle", 32'(busy), 32'd0);

    // Reset mid-sweep with partial error state present.
    f_or1 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("rst_pre_mask", 32'(err_mask), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_mid");
    check("rst_mid_pass", 32'(pass), 32'd0);
    check("rst_mid_mask", 32'(err_mask), 32'd0);
    check("rst_mid_log", 32'(out_log), 32'd0);
    seen = 0;
    repeat (15) begin
      tick();
      if (done || busy) seen = 1;
    end
    check("rst_quiet", 32'(seen), 32'd0);

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    check_idle_outputs("start_abort");
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy2", 32'(busy), 32'd0);
    tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
